fir_sample_feeder: RTL
======================

# fir_sample_feeder

Upstream source stage for the `FIR` block. Accepts signed 16-bit PCM samples over a valid/ready stream and converts each one exactly to IEEE-754 single precision. Converted samples are buffered in a FIFO and one is presented on `sample` (wired to `FIR.in`) per rising edge of the filter's `next` request. Drives `FIR.stop` once the tagged last sample has been handed over.

## Interface
- `DEPTH`, 16: FIFO entries (power of two, ≥4), each 32-bit float.
- `DATA_W`, 16: input sample width; fixed at 16 for this revision.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset; clears all state.
- `s_valid`  in  1  input sample valid.
- `s_data`  in  16  signed two's-complement sample.
- `s_last`  in  1  marks final sample of the block; qualified by `s_valid`.
- `s_ready`  out  1  feeder can accept a sample this cycle.
- `next`  in  1  sample request from `FIR`; level signal, edge-detected here.
- `sample`  out  32  current float32 sample to `FIR.in`.
- `stop`  out  1  to `FIR.stop`; sticky.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `underflow`  out  1  sticky: a request arrived with the FIFO empty.

## Operation
- Input accept: transfer when `s_valid && s_ready`. `s_ready = (level + inflight) < DEPTH`, where inflight counts valid conversion-pipeline stages (0–2).
- Conversion pipeline, 2 stages:
  - S1: register sign, 17-bit magnitude (handles -32768), `last` tag.
  - S2: priority-encode leading one position p (0..15); exponent = 127+p; mantissa = magnitude bits below the leading one, left-aligned into 23 bits, zero-filled. Exact, no rounding. Magnitude 0 → 0x00000000 (never -0).
  - S2 output writes FIFO entry {float, last}.
- Request: `next_rise = next && !next_q`. Only the rising edge pops; a held-high `next` pops once.
- On `next_rise` with FIFO non-empty: pop; `sample` ← entry float. If entry tag `last`, set `stop`.
- On `next_rise` with FIFO empty: `sample` ← 0x00000000; set `underflow`. No pop.
- Once `stop` is set, further `next_rise` still pop if data exists; `stop` remains 1.
- Simultaneous FIFO write and pop in one cycle: `level` unchanged; legal at empty only if written data is not the popped data (pop sees the pre-write state, so it underflows).
- States: EMPTY (level=0), FILL (0<level<DEPTH), FULL (level=DEPTH), derived from level. `stop` and `underflow` clear only on `rst`.

## Timing
- Reset values: `s_ready`=1, `sample`=0x00000000, `stop`=0, `underflow`=0, `level`=0; `next_q`=0.
- Accept-to-FIFO latency: sample accepted at edge N is in FIFO (counted in `level`) after edge N+2.
- Request latency: `next` rising sampled at edge N → `sample`, `stop`, `underflow` updated after edge N+1 (one registered stage). `sample` is stable for all other cycles.
- `FIR` samples `in` ≥2 cycles after raising `next`, so the update is ready in time.
- Throughput: one accept per cycle until full; `s_ready` is registered-path-free (combinational from counters only).
- `rst` asserted mid-operation: all outputs return to reset values immediately; pipeline and FIFO contents discarded.

## Configuration
- `FIR_FEEDER_Q15_EN`: defined → input read as Q1.15; exponent = 112+p (value/32768, range [-1,1)). Undefined → input read as integer; exponent = 127+p. All other behaviour identical.

## Test plan
- Reset then push 1, 3, -32768, 16384 (Q15 undefined); pulse `next` 4× → `sample` 0x3F800000, 0x40400000, 0xC7000000, 0x46800000; `underflow`=0.
- Same with `FIR_FEEDER_Q15_EN` → 0x38000000, 0x38C00000, 0xBF800000, 0x3F000000; push 0 → 0x00000000.
- Hold `s_valid`=1 without `next` → exactly 16 accepts, `level`=16, `s_ready`=0; one `next` pulse → `s_ready`=1 next cycle, `level`=15.
- Hold `next` high 5 cycles with 3 entries → exactly one pop, `level` 3→2.
- `next` rising with FIFO empty → `sample`=0x00000000, `underflow`=1 and stays 1 after later pops.
- Push 5 samples, last with `s_last`=1; 5 `next` pulses → `stop` 0 for pulses 1–4, 1 one cycle after pulse 5; assert `rst` → `stop`=0, `level`=0.

Source files
------------

// File: rtl/fir_sample_feeder_if.sv
// Sample stream into the FIR feeder: valid/ready handshake with a last-sample tag.
interface fir_sample_feeder_if #(
  parameter int unsigned DATA_W = 16
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/fir_sample_feeder.sv
// Converts signed PCM samples to float32 and feeds them to FIR on each rising edge of next.
// Define FIR_FEEDER_Q15_EN to read inputs as Q1.15 instead of integers.
module fir_sample_feeder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fir_sample_feeder_if.slave       s,
  input  logic                     next,
  output logic [31:0]              sample,
  output logic                     stop,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CW    = LW + 1;
  localparam int unsigned MAG_W = DATA_W + 1;
`ifdef FIR_FEEDER_Q15_EN
  localparam int unsigned EXP_BIAS = 112;
`else
  localparam int unsigned EXP_BIAS = 127;
`endif

  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

  state_t            state_q, state_d;
  logic              s1_valid, s1_sign, s1_last;
  logic [MAG_W-1:0]  s1_mag;
  logic              s2_valid, s2_last;
  logic [31:0]       s2_word;
  logic [32:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              next_q, req_q;
  logic [LW-1:0]     level_d;
  logic [31:0]       sample_d;
  logic              stop_d, underflow_d;

  logic [1:0]        inflight_c;
  logic              accept_c, pop_c, next_rise_c;
  logic [MAG_W-1:0]  ext_c, mag_c;
  logic [4:0]        lead_c;
  logic [23:0]       shift_c;
  logic [31:0]       word_c;
  logic [32:0]       rd_word_c;

  // Space check counts conversions still in flight so the FIFO can never overrun.
  assign inflight_c = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign s.s_ready  = (CW'(level) + CW'(inflight_c)) < CW'(DEPTH);
  assign accept_c   = s.s_valid && s.s_ready;

  assign ext_c = {s.s_data[DATA_W-1], s.s_data};
  assign mag_c = ext_c[MAG_W-1] ? MAG_W'(-ext_c) : ext_c;

  // Leading-one position; highest set bit wins.
  always_comb begin
    lead_c = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (s1_mag[i]) lead_c = 5'(i);
    end
  end

  // Shift the leading one up to bit 23 so the bits below it form the mantissa.
  assign shift_c = 24'(s1_mag[DATA_W-1:0]) << (5'd23 - lead_c);
  assign word_c  = (s1_mag == '0) ? 32'h0000_0000
                 : {s1_sign, 8'(EXP_BIAS + 32'(lead_c)), shift_c[22:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_last  <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_sign <= s.s_data[DATA_W-1];
        s1_mag  <= mag_c;
        s1_last <= s.s_last;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_word <= word_c;
        s2_last <= s1_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s2_valid) mem[wr_ptr] <= {s2_last, s2_word};
  end

  assign rd_word_c   = mem[rd_ptr];
  assign next_rise_c = next && !next_q;
  // Pop decision uses the pre-write state, so a same-cycle write to an empty FIFO still underflows.
  assign pop_c       = req_q && (state_q != EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      next_q    <= 1'b0;
      req_q     <= 1'b0;
      sample    <= '0;
      stop      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      level     <= level_d;
      next_q    <= next;
      req_q     <= next_rise_c;
      sample    <= sample_d;
      stop      <= stop_d;
      underflow <= underflow_d;
      if (s2_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)    rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_comb begin
    level_d     = level;
    state_d     = state_q;
    sample_d    = sample;
    stop_d      = stop;
    underflow_d = underflow;

    case ({s2_valid, pop_c})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: level_d = level;
    endcase

    if (level_d == '0)               state_d = EMPTY;
    else if (level_d == LW'(DEPTH))  state_d = FULL;
    else                             state_d = FILL;

    if (req_q) begin
      if (state_q != EMPTY) begin
        sample_d = rd_word_c[31:0];
        stop_d   = stop | rd_word_c[32];
      end else begin
        sample_d    = 32'h0000_0000;
        underflow_d = 1'b1;
      end
    end
  end

endmodule
